// File: rtl/cache_pkg.sv
// Shared types, field widths and address-decode helper for the MEM-stage data cache.
package cache_pkg;

    localparam int unsigned TAG_W    = 10;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned BLK_W    = 64;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned WSEL_BIT = 2;
    localparam int unsigned IDX_LSB  = 3;
    localparam int unsigned TAG_LSB  = IDX_LSB + IDX_W;
    localparam int unsigned FLD_W    = TAG_W + IDX_W + 1;

    localparam logic [31:0] BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic             wsel;
    } addr_fields_t;

    // Split the meaningful bits {tag, index, word-select} of an offset address.
    function automatic addr_fields_t decode_addr(input logic [FLD_W-1:0] a);
        addr_fields_t f;
        f.wsel = a[0];
        f.idx  = a[IDX_W:1];
        f.tag  = a[FLD_W-1:IDX_W+1];
        return f;
    endfunction

endpackage

// File: rtl/cache_set_array.sv
// Two-way tag/data store with per-set LRU bit; combinational lookup, synchronous writes.
module cache_set_array
    import cache_pkg::*;
#(
    parameter int unsigned SETS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    input  logic              wsel,
    output logic              hit,
    output logic              hit_way,
    output logic [WORD_W-1:0] word,
    output logic              victim,
    input  logic              fill_en,
    input  logic              fill_way,
    input  logic [BLK_W-1:0]  fill_blk,
    input  logic              upd_en,
    input  logic              upd_way,
    input  logic [WORD_W-1:0] upd_word,
    input  logic              lru_en,
    input  logic              lru_val
);

    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_q  [2][SETS];
    logic [BLK_W-1:0]     data_q [2][SETS];
    logic [1:0]           way_hit;
    logic [BLK_W-1:0]     blk;

    // Tag compare in both ways and word select from the hitting block.
    always_comb begin
        way_hit[0] = valid_q[0][idx] && (tag_q[0][idx] == tag);
        way_hit[1] = valid_q[1][idx] && (tag_q[1][idx] == tag);
        hit        = |way_hit;
        hit_way    = way_hit[1];
        blk        = way_hit[1] ? data_q[1][idx] : data_q[0][idx];
        word       = wsel ? blk[BLK_W-1:WORD_W] : blk[WORD_W-1:0];
        victim     = lru_q[idx];
    end

    // Valid and LRU state; reset invalidates every line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (fill_en) valid_q[fill_way][idx] <= 1'b1;
            if (lru_en)  lru_q[idx] <= lru_val;
        end
    end

    // Tag and data storage: block fill or single-word store update.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_way][idx]  <= tag;
            data_q[fill_way][idx] <= fill_blk;
        end else if (upd_en) begin
            if (wsel) data_q[upd_way][idx][BLK_W-1:WORD_W] <= upd_word;
            else      data_q[upd_way][idx][WORD_W-1:0]     <= upd_word;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// MEM-stage load/store controller: 2-way write-through cache in front of the SRAM controller.
module cache_controller #(
    parameter logic [31:0] BASE_ADDR = cache_pkg::BASE_ADDR,
    parameter int unsigned SETS      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    import cache_pkg::*;

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       eff;
    addr_fields_t      fld;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic [WORD_W-1:0] hit_word;
    logic              fill_en;
    logic              upd_en;
    logic              lru_en;
    logic              lru_val;
    logic              unused_addr_bits;

    assign eff              = addr - BASE_ADDR;
    assign fld              = decode_addr(eff[TAG_LSB+TAG_W-1:WSEL_BIT]);
    assign unused_addr_bits = ^{eff[31:TAG_LSB+TAG_W], eff[WSEL_BIT-1:0]};
    assign sram_addr        = addr;
    assign sram_wdata       = wdata;

    cache_set_array #(.SETS(SETS)) u_array (
        .clk      (clk),
        .rst      (rst),
        .idx      (fld.idx),
        .tag      (fld.tag),
        .wsel     (fld.wsel),
        .hit      (hit),
        .hit_way  (hit_way),
        .word     (hit_word),
        .victim   (victim),
        .fill_en  (fill_en),
        .fill_way (victim),
        .fill_blk (sram_rdata),
        .upd_en   (upd_en),
        .upd_way  (hit_way),
        .upd_word (wdata),
        .lru_en   (lru_en),
        .lru_val  (lru_val)
    );

    // State register; reset abandons any SRAM access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: stores always go through SRAM, loads only on a miss.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_en)               state_d = WRITE;
                else if (rd_en && !hit)  state_d = RMISS;
            end
            RMISS, WRITE: begin
                if (sram_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and cache write strobes; ready drops in the detection cycle to freeze the pipe.
    always_comb begin
        ready      = 1'b1;
        rdata      = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        lru_en     = 1'b0;
        lru_val    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    ready = 1'b0;
                    if (hit) begin
                        upd_en  = 1'b1;
                        lru_en  = 1'b1;
                        lru_val = ~hit_way;
                    end
                end else if (rd_en) begin
                    if (hit) begin
                        rdata   = hit_word;
                        lru_en  = 1'b1;
                        lru_val = ~hit_way;
                    end else begin
                        ready = 1'b0;
                    end
                end
            end
            RMISS: begin
                sram_rd_en = 1'b1;
                if (sram_ready) begin
                    fill_en = 1'b1;
                    lru_en  = 1'b1;
                    lru_val = ~victim;
                    rdata   = fld.wsel ? sram_rdata[BLK_W-1:WORD_W] : sram_rdata[WORD_W-1:0];
                end else begin
                    ready = 1'b0;
                end
            end
            WRITE: begin
                sram_wr_en = 1'b1;
                ready      = sram_ready;
            end
            default: ready = 1'b1;
        endcase
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Memory-stage controller for the pipelined ARM core. It sits between the MEM stage and the external SRAM controller and serves loads from a 2-way set-associative, write-through, no-write-allocate data cache. While it sequences an SRAM access, it deasserts `ready`, which freezes every pipeline register. The forwarding selects are therefore held stable for the whole miss.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address subtracted from the ALU address before decoding.
- `SETS`, default 64: number of cache sets.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `rd_en`, in, 1: MEM-stage load request.
- `wr_en`, in, 1: MEM-stage store request.
- `addr`, in, 32: byte address from the ALU.
- `wdata`, in, 32: store data.
- `rdata`, out, 32: load data.
- `ready`, out, 1: request complete; low means the pipeline is frozen.
- `sram_rd_en`, out, 1: SRAM block-read request.
- `sram_wr_en`, out, 1: SRAM word-write request.
- `sram_addr`, out, 32: SRAM byte address, equal to `addr` as presented.
- `sram_wdata`, out, 32: SRAM write data, equal to `wdata`.
- `sram_rdata`, in, 64: SRAM 64-bit block `{word1, word0}`.
- `sram_ready`, in, 1: one-cycle SRAM completion pulse.

## Operation
- Address decode: `eff = addr - BASE_ADDR`.
  - `eff[2]` selects the word within the block.
  - `eff[8:3]` is the set index.
  - `eff[18:9]` is the 10-bit tag.
  - `eff[1:0]` is ignored.
- Per set: two ways of {valid, tag[9:0], data[63:0]} and one LRU bit. LRU=0 means way 0 is the victim.
- Hit: valid and tag match in exactly one way. A double hit cannot occur by construction.
- FSM states:
  - IDLE
    - `rd_en` & hit → stay in IDLE. `rdata` is the hit word, `ready`=1, LRU points to the other way.
    - `rd_en` & miss → go to RMISS.
    - `wr_en` → go to WRITE. If the store hits, update that word in the cache and set LRU to the other way.
  - RMISS
    - Hold `sram_rd_en`=1 until `sram_ready`.
    - On `sram_ready`: write `sram_rdata` into the victim way (valid=1, new tag), flip LRU, drive `rdata` from `sram_rdata`, `ready`=1, return to IDLE.
  - WRITE
    - Hold `sram_wr_en`=1 until `sram_ready`.
    - On `sram_ready`: `ready`=1, return to IDLE.
- `rd_en` and `wr_en` both high: `wr_en` wins and the load is ignored. The MEM stage never issues this.
- Neither request: `ready`=1, no state change, and no SRAM strobes.
- Requesters hold `addr`, `wdata`, `rd_en` and `wr_en` stable while `ready`=0. The freeze guarantees this, so the controller latches nothing.
- Store misses do not allocate.

## Timing
- Reset values:
  - State IDLE.
  - All valid and LRU bits 0.
  - `sram_rd_en`=0, `sram_wr_en`=0, `rdata`=0 when idle, `ready`=1.
- Read-hit latency: 0 cycles. `rdata` and `ready` are combinational in the request cycle.
- `ready` is combinational:
  - It goes low in the same cycle as a miss or store is detected in IDLE, so the freeze takes effect at the next edge.
  - It returns high in the cycle `sram_ready`=1.
- Read-miss latency: 1 cycle plus the SRAM latency. The fill is written at the edge that ends the `sram_ready` cycle.
- `sram_rd_en` and `sram_wr_en` are Moore outputs of RMISS and WRITE respectively. They are never high together.
- `sram_ready` while in IDLE is ignored.
- Reset mid-miss or mid-write:
  - Return to IDLE immediately and drop the strobes.
  - Clear all valid bits. No partial fill is written.
- `sram_ready` asserted in the first RMISS or WRITE cycle is legal and completes that cycle.

## Structure
- Shared package `cache_pkg`:
  - State enum {IDLE, RMISS, WRITE}.
  - Field widths TAG_W=10, IDX_W=6, BLK_W=64.
  - Constant BASE_ADDR.
- One sub-module, `cache_set_array`, holds the valid, tag, data and LRU storage. It has:
  - a combinational lookup port returning hit, hit_way and word;
  - a synchronous write port for fill, word-update and LRU.
- The FSM and the SRAM handshake live in `cache_controller`.

## Test plan
- Cold read:
  - Reset, then `rd_en` at `addr`=1024 with SRAM returning `64'h0000_0002_0000_0001` after 3 cycles.
  - Required: `ready`=0 for 4 cycles, `rdata`=1 in the completion cycle, and a reread of 1024 hits with `rdata`=1 in 0 cycles.
- Word select: after the fill above, a read of 1028 hits with `rdata`=2 and no `sram_rd_en`.
- LRU eviction:
  - Fill tags A then B into set 0, read A again, then miss on C into set 0.
  - Required: B's way is replaced; A still hits and B misses.
- Write-through:
  - Store 0xDEAD to cached 1024.
  - Required: `sram_wr_en` is held until `sram_ready`, and a following read of 1024 hits with `rdata`=0xDEAD.
- Store miss: a store to uncached 2048 completes via SRAM, and a subsequent read of 2048 misses, showing no allocate.
- Reset mid-miss: assert `rst`=0 during RMISS; both strobes drop asynchronously, and a read of any address misses afterwards.
